// File: rtl/code_entry_ctrl.sv
// Electronic-lock code logic: collects BCD key pulses, checks them against a stored
// password, supports password change while open and a timed lockout after repeated failures.
module code_entry_ctrl #(
    parameter int                   DIGITS      = 4,
    parameter int                   MAXFAIL     = 3,
    parameter int                   LOCKOUT_CYC = 1000000,
    parameter logic [4*DIGITS-1:0]  INIT_PW     = 16'h1234
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [9:0]                    key,
    input  logic                          enter,
    input  logic                          clear,
    input  logic                          set,
    output logic [4*DIGITS-1:0]           disp,
    output logic [$clog2(DIGITS+1)-1:0]   ndig,
    output logic                          open,
    output logic                          alarm,
    output logic                          err
);

    localparam int W  = 4 * DIGITS;
    localparam int NW = $clog2(DIGITS + 1);
    localparam int FW = (MAXFAIL > 1) ? $clog2(MAXFAIL) : 1;
    localparam int TW = (LOCKOUT_CYC > 1) ? $clog2(LOCKOUT_CYC) : 1;

    localparam logic [NW-1:0] FULL       = NW'(DIGITS);
    localparam logic [FW-1:0] FAIL_LAST  = FW'(MAXFAIL - 1);
    localparam logic [TW-1:0] TIMER_INIT = TW'(LOCKOUT_CYC - 1);

    typedef enum logic [1:0] {
        LOCKED  = 2'd0,
        OPEN    = 2'd1,
        SETPW   = 2'd2,
        LOCKOUT = 2'd3
    } state_t;

    state_t          state, state_n;
    logic [W-1:0]    pw, pw_n;
    logic [W-1:0]    disp_n;
    logic [NW-1:0]   ndig_n;
    logic [FW-1:0]   failcnt, failcnt_n;
    logic [TW-1:0]   timer, timer_n;
    logic            err_n;

    function automatic logic [3:0] key_digit(input logic [9:0] k);
        logic [3:0] d;
        d = '0;
        for (int i = 0; i < 10; i++) begin
            if (k[i]) d = 4'(i);
        end
        return d;
    endfunction

    assign open  = (state == OPEN) || (state == SETPW);
    assign alarm = (state == LOCKOUT);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state   <= LOCKED;
            pw      <= INIT_PW;
            disp    <= '0;
            ndig    <= '0;
            failcnt <= '0;
            timer   <= '0;
            err     <= 1'b0;
        end else begin
            state   <= state_n;
            pw      <= pw_n;
            disp    <= disp_n;
            ndig    <= ndig_n;
            failcnt <= failcnt_n;
            timer   <= timer_n;
            err     <= err_n;
        end
    end

    // Only the highest-priority event (clear > enter > set > key) is acted on each cycle.
    always_comb begin
        state_n   = state;
        pw_n      = pw;
        disp_n    = disp;
        ndig_n    = ndig;
        failcnt_n = failcnt;
        timer_n   = timer;
        err_n     = 1'b0;

        case (state)
            LOCKOUT: begin
                disp_n = '0;
                ndig_n = '0;
                if (timer == '0) begin
                    state_n = LOCKED;
                end else begin
                    timer_n = timer - TW'(1);
                end
            end
            default: begin
                if (clear) begin
                    disp_n = '0;
                    ndig_n = '0;
                end else if (enter) begin
                    disp_n = '0;
                    ndig_n = '0;
                    if (state == LOCKED) begin
                        if ((ndig == FULL) && (disp == pw)) begin
                            state_n   = OPEN;
                            failcnt_n = '0;
                        end else begin
                            err_n = 1'b1;
                            if (failcnt == FAIL_LAST) begin
                                state_n   = LOCKOUT;
                                timer_n   = TIMER_INIT;
                                failcnt_n = '0;
                            end else begin
                                failcnt_n = failcnt + FW'(1);
                            end
                        end
                    end else if (state == OPEN) begin
                        state_n = LOCKED;
                    end else begin
                        if (ndig == FULL) begin
                            pw_n    = disp;
                            state_n = OPEN;
                        end else begin
                            err_n = 1'b1;
                        end
                    end
                end else if (set) begin
                    // A fresh entry buffer is used for the new password.
                    if (state == OPEN) begin
                        state_n = SETPW;
                        disp_n  = '0;
                        ndig_n  = '0;
                    end
                end else if ($onehot(key) && (ndig != FULL)) begin
                    disp_n = (disp << 4) | W'(key_digit(key));
                    ndig_n = ndig + NW'(1);
                end
            end
        endcase
    end

endmodule
